// File: rtl/irq_unit.sv
// irq_unit: machine-mode interrupt unit.
// Owns mstatus (MIE/MPIE), mie, mip and mcause, arbitrates pending
// interrupts and hands a trap request to the core at instruction boundaries.
// Optional macro IRQ_SYNC_EN: when defined, external_int is passed through a
// two-flop synchronizer before it reaches mip.MEIP.
module irq_unit #(
  parameter int          XLEN        = 32,
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            software_int,
  input  logic            timer_int,
  input  logic            external_int,
  input  logic            csr_we,
  input  logic [11:0]     csr_addr,
  input  logic [XLEN-1:0] csr_wdata,
  output logic [XLEN-1:0] csr_rdata,
  output logic            csr_hit,
  input  logic            instr_boundary,
  input  logic            mret,
  output logic            trap_req,
  output logic [XLEN-1:0] trap_cause,
  input  logic            trap_ack
);

  localparam logic [11:0] ADDR_MSTATUS = 12'h300;
  localparam logic [11:0] ADDR_MIE     = 12'h304;
  localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
  localparam logic [11:0] ADDR_MIP     = 12'h344;

  typedef enum logic {IDLE, REQ} state_t;

  state_t          state_q, state_d;
  logic            mstatus_mie, mstatus_mpie;
  logic            mie_msie, mie_mtie, mie_meie;
  logic [XLEN-1:0] mcause_q;
  logic [XLEN-1:0] cause_q;
  logic            meip;
  logic            pend_msi, pend_mti, pend_mei;
  logic [3:0]      win_code;
  logic            take_trap, commit_trap;

  // MTVEC_RESET only keeps the core interface stable; mode 2'b11 is reserved
  // and deliberately produces no hardware.
  if (MTVEC_RESET[1:0] == 2'b11) begin : g_mtvec_reserved_mode
  end

`ifdef IRQ_SYNC_EN
  logic ext_sync1, ext_sync2;

  // Two-flop synchronizer for the asynchronous external interrupt line.
  always_ff @(posedge clk) begin
    if (rst) begin
      ext_sync1 <= 1'b0;
      ext_sync2 <= 1'b0;
    end else begin
      ext_sync1 <= external_int;
      ext_sync2 <= ext_sync1;
    end
  end

  assign meip = ext_sync2;
`else
  assign meip = external_int;
`endif

  // Pending set and fixed-priority pick: MEI over MSI over MTI.
  always_comb begin
    pend_msi = software_int & mie_msie;
    pend_mti = timer_int    & mie_mtie;
    pend_mei = meip         & mie_meie;
    win_code = 4'd7;
    if (pend_mei) begin
      win_code = 4'd11;
    end else if (pend_msi) begin
      win_code = 4'd3;
    end
  end

  // Trap FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Trap FSM next state; a committed request is held until the core acks it.
  always_comb begin
    state_d     = state_q;
    take_trap   = 1'b0;
    commit_trap = 1'b0;
    trap_req    = 1'b0;
    case (state_q)
      IDLE: begin
        if (instr_boundary && mstatus_mie && (pend_msi || pend_mti || pend_mei)) begin
          take_trap = 1'b1;
          state_d   = REQ;
        end
      end
      REQ: begin
        trap_req = 1'b1;
        if (trap_ack) begin
          commit_trap = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Latched trap cause, frozen for the whole request.
  always_ff @(posedge clk) begin
    if (rst) begin
      cause_q <= '0;
    end else if (take_trap) begin
      cause_q <= {1'b1, {(XLEN-5){1'b0}}, win_code};
    end else if (commit_trap) begin
      cause_q <= '0;
    end
  end

  assign trap_cause = cause_q;

  // mstatus: trap entry beats mret, and both beat a software write.
  always_ff @(posedge clk) begin
    if (rst) begin
      mstatus_mie  <= 1'b0;
      mstatus_mpie <= 1'b0;
    end else if (commit_trap) begin
      mstatus_mpie <= mstatus_mie;
      mstatus_mie  <= 1'b0;
    end else if (mret) begin
      mstatus_mie  <= mstatus_mpie;
      mstatus_mpie <= 1'b1;
    end else if (csr_we && csr_addr == ADDR_MSTATUS) begin
      mstatus_mie  <= csr_wdata[3];
      mstatus_mpie <= csr_wdata[7];
    end
  end

  // mie enable bits; software writes always land.
  always_ff @(posedge clk) begin
    if (rst) begin
      mie_msie <= 1'b0;
      mie_mtie <= 1'b0;
      mie_meie <= 1'b0;
    end else if (csr_we && csr_addr == ADDR_MIE) begin
      mie_msie <= csr_wdata[3];
      mie_mtie <= csr_wdata[7];
      mie_meie <= csr_wdata[11];
    end
  end

  // mcause: the committed trap cause wins over a coincident software write.
  always_ff @(posedge clk) begin
    if (rst) begin
      mcause_q <= '0;
    end else if (commit_trap) begin
      mcause_q <= cause_q;
    end else if (csr_we && csr_addr == ADDR_MCAUSE) begin
      mcause_q <= csr_wdata;
    end
  end

  // Combinational CSR read mux and address decode.
  always_comb begin
    csr_rdata = '0;
    csr_hit   = 1'b0;
    case (csr_addr)
      ADDR_MSTATUS: begin
        csr_hit         = 1'b1;
        csr_rdata[12:11] = 2'b11;
        csr_rdata[7]    = mstatus_mpie;
        csr_rdata[3]    = mstatus_mie;
      end
      ADDR_MIE: begin
        csr_hit       = 1'b1;
        csr_rdata[11] = mie_meie;
        csr_rdata[7]  = mie_mtie;
        csr_rdata[3]  = mie_msie;
      end
      ADDR_MIP: begin
        csr_hit       = 1'b1;
        csr_rdata[11] = meip;
        csr_rdata[7]  = timer_int;
        csr_rdata[3]  = software_int;
      end
      ADDR_MCAUSE: begin
        csr_hit   = 1'b1;
        csr_rdata = mcause_q;
      end
      default: begin
        csr_hit   = 1'b0;
        csr_rdata = '0;
      end
    endcase
  end

endmodule

// File: doc/irq_unit.md
Name: irq_unit

Overview:
- Machine-mode interrupt unit that consumes `software_int` and `timer_int` from the CLINT and an external interrupt line.
- Owns the interrupt CSRs `mstatus` (MIE/MPIE), `mie`, `mip` and `mcause`.
- Arbitrates pending interrupts and raises a trap request to the multicycle core's control FSM at instruction boundaries.
- Sits between the peripherals and the core's CSR/trap logic.

Parameters:
- `XLEN`, 32, CSR data width.
- `MTVEC_RESET`, 32'h0000_0000: reserved for trap-vector integration; unused internally and carried to keep the core interface stable.

Ports:
- `clk` input 1: system clock.
- `rst` input 1: synchronous, active-high reset.
- `software_int` input 1: MSIP from the CLINT, level.
- `timer_int` input 1: MTIP from the CLINT, level.
- `external_int` input 1: MEIP from an external source, level, possibly asynchronous.
- `csr_we` input 1: CSR write strobe from the core.
- `csr_addr` input 12: CSR address.
- `csr_wdata` input XLEN: CSR write data, already resolved for CSRRW/S/C by the core.
- `csr_rdata` output XLEN: combinational read data for `csr_addr`.
- `csr_hit` output 1: `csr_addr` is one of the four CSRs owned here.
- `instr_boundary` input 1: the core is in its fetch state and may take a trap.
- `mret` input 1: the core is executing MRET, one-cycle pulse.
- `trap_req` output 1: interrupt trap requested.
- `trap_cause` output XLEN: `{1'b1, 27'b0, code[3:0]}` while `trap_req` is high.
- `trap_ack` input 1: the core has committed the trap, one-cycle pulse.

Behaviour:
- All state is updated on `posedge clk`.
- When `rst` is high, the following reset values apply:
  - `mstatus.MIE` = 0, `mstatus.MPIE` = 0, `mie` = 0, `mcause` = 0.
  - FSM is in IDLE, `trap_req` = 0, `trap_cause` = 0, and the synchronizer flops = 0.
- CSR map:
  - `mstatus` (0x300): bit3 MIE and bit7 MPIE are read/write; bits 12:11 MPP read 2'b11 and ignore writes; all other bits read 0.
  - `mie` (0x304): bits 3, 7 and 11 are read/write; all other bits read 0 and ignore writes.
  - `mip` (0x344): read-only. bit3 = `software_int`, bit7 = `timer_int`, bit11 = the `meip` signal. Writes are ignored.
  - `mcause` (0x342): full read/write.
- Unmapped addresses: `csr_hit` = 0, `csr_rdata` = 0, and writes have no effect.
- A CSR write takes effect on the clock edge, so the new value is visible on the next cycle.
- `pending = mip & mie`, masked to bits 3, 7 and 11.
- Priority: MEI (code 11) > MSI (code 3) > MTI (code 7).
- FSM has two states, IDLE and REQ.
- IDLE → REQ when `instr_boundary` && MIE && `pending` != 0. On that edge:
  - `trap_cause` latches the highest-priority code.
  - `trap_req` goes high starting the next cycle, i.e. one cycle of latency after the qualifying cycle.
- In REQ:
  - `trap_req` and `trap_cause` hold even if the source deasserts or a CSR write clears `mie`/MIE. A committed request is never withdrawn.
- REQ → IDLE on `trap_ack`. On that edge:
  - MPIE <= MIE, MIE <= 0.
  - `mcause` <= `trap_cause`.
  - `trap_req` <= 0 and `trap_cause` <= 0.
- `trap_ack` while in IDLE is ignored.
- `mret` (in any state, when not coinciding with `trap_ack`): MIE <= MPIE, MPIE <= 1.
- Simultaneous events in one cycle:
  - `trap_ack` updates beat `mret`; `mret` is ignored.
  - `trap_ack`/`mret` updates beat a CSR write to `mstatus`; the CSR write to `mstatus` is dropped.
  - A CSR write to `mcause` coinciding with `trap_ack` is dropped; the trap value wins.
  - A CSR write to `mie` is always applied.
- Reset mid-REQ: `trap_req` drops in the cycle following the reset edge, and no `mcause` update occurs.
- If no interrupt is pending, the FSM never leaves IDLE, regardless of `instr_boundary`.

Optional Feature:
- Macro: `IRQ_SYNC_EN`.
- Defined: `external_int` passes through a 2-flop synchronizer (reset to 0), and `meip` is the output of the second flop. This adds 2 cycles of latency from `external_int` to `mip.bit11`.
- Undefined: `meip` = `external_int` directly, with zero latency; the source must then be synchronous to `clk`.
- `software_int` and `timer_int` are never synchronized, since they are already synchronous to `clk`.

Test Plan:
- Reset, then read 0x300/0x304/0x344/0x342 with all inputs at 0 → `csr_rdata` = 0x1800, 0, 0, 0; `trap_req` = 0.
- Write `mie` = 0x888 and `mstatus` = 0x8, hold `timer_int` = 1 and `instr_boundary` = 1 → `trap_req` = 1 one cycle later with `trap_cause` = 0x8000_0007. Pulse `trap_ack` → `mcause` = 0x8000_0007, `mstatus` reads 0x1880 (MIE = 0, MPIE = 1), `trap_req` = 0.
- With all three sources pending and enabled → `trap_cause` = 0x8000_000B. Repeat with only software and timer pending → `trap_cause` = 0x8000_0003.
- Enter REQ on MTI, then deassert `timer_int` and write `mie` = 0 → `trap_req` stays 1 with cause 0x8000_0007 until `trap_ack`.
- After the trap is taken (MIE = 0, MPIE = 1), pulse `mret` → `mstatus` = 0x1888. Pulse `mret` together with a `mstatus` write of 0 → `mstatus` = 0x1888 (the write is dropped).
- With `IRQ_SYNC_EN` defined, raise `external_int` → `mip.bit11` = 1 exactly 2 cycles later. Assert `rst` while in REQ → `trap_req` = 0 and `mcause` = 0 in the cycle after the reset edge.
